// File: rtl/pixel_readout.sv
// pixel_readout: captures one row of column ADC codes per read1/read2 strobe
// and streams them, tagged with frame/line markers, through a small
// first-word-fall-through FIFO onto a valid/ready pixel interface.
//
// Optional feature macro: PIXEL_READOUT_GRAY_DECODE_EN
//   defined   -> each code is gray-to-binary converted as it enters the FIFO
//   undefined -> codes pass through unchanged

module pixel_readout #(
    parameter int COLS       = 2,
    parameter int DW         = 8,
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read1,
    input  logic                read2,
    input  logic [COLS*DW-1:0]  data_in,
    input  logic                pix_ready,
    output logic                pix_valid,
    output logic [DW-1:0]       pix_data,
    output logic                pix_sof,
    output logic                pix_eol,
    output logic                pix_eof,
    output logic                overflow,
    output logic                short_read,
    output logic                busy
);

    // Derived widths. The counters are sized for at least two values so a
    // parameter of 1 still yields a legal one-bit register.
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = $clog2((SETTLE_CYC > 1) ? SETTLE_CYC : 2);
    localparam int COLW = $clog2((COLS > 1) ? COLS : 2);
    localparam int EW   = DW + 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Control and capture registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  row_q, row_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [COLW-1:0]       col_q, col_d;
    logic [COLS*DW-1:0]    shadow_q, shadow_d;
    logic                  read1_q, read2_q;
    logic                  short_read_q;
    logic                  overflow_q;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  rise1;
    logic                  rise2;
    logic                  strobe_sel;
    logic                  wr_req;
    logic                  short_set;
    logic                  fifo_full;
    logic                  pop;
    logic                  wr_ok;
    logic [DW-1:0]         raw_code;
    logic [DW-1:0]         wr_code;
    logic                  wr_sof;
    logic                  wr_eol;
    logic                  wr_eof;
    logic [EW-1:0]         wr_word;
    logic [EW-1:0]         head_word;

    // A rise is a strobe that is high now but was low at the previous edge.
    assign rise1 = read1 & ~read1_q;
    assign rise2 = read2 & ~read2_q;

    // The strobe that opened the current row is the one watched during SETTLE.
    assign strobe_sel = row_q ? read2 : read1;

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        b[DW-1] = g[DW-1];
        for (int i = DW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    // Code and tags of the word CAPTURE offers in the current cycle.
    assign raw_code = shadow_q[col_q*DW +: DW];

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    assign wr_code = gray2bin(raw_code);
`else
    assign wr_code = raw_code;
`endif

    assign wr_sof  = (row_q == 1'b0) && (col_q == '0);
    assign wr_eol  = (col_q == COLW'(COLS - 1));
    assign wr_eof  = (row_q == 1'b1) && (col_q == COLW'(COLS - 1));
    assign wr_word = {wr_sof, wr_eol, wr_eof, wr_code};

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign pop       = (count_q != '0) & pix_ready;
    assign wr_ok     = wr_req & (~fifo_full | pop);

    // Strobe history, state and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            row_q    <= 1'b0;
            cnt_q    <= '0;
            col_q    <= '0;
            shadow_q <= '0;
            read1_q  <= 1'b0;
            read2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            shadow_q <= shadow_d;
            read1_q  <= read1;
            read2_q  <= read2;
        end
    end

    // Next-state logic: accept a rise in IDLE, wait out the settle window,
    // then emit one word per column.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        shadow_d  = shadow_q;
        wr_req    = 1'b0;
        short_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise1) begin
                    row_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (rise2) begin
                    row_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (!strobe_sel) begin
                    short_set = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNTW'(SETTLE_CYC - 1)) begin
                    shadow_d = data_in;
                    col_d    = '0;
                    state_d  = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            CAPTURE: begin
                wr_req = 1'b1;
                if (col_q == COLW'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = IDLE;
                end else begin
                    col_d = col_q + COLW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy; a dropped word leaves all of them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_word;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q   <= 1'b0;
            short_read_q <= 1'b0;
        end else begin
            overflow_q   <= overflow_q | (wr_req & ~wr_ok);
            short_read_q <= short_read_q | short_set;
        end
    end

    // Outputs come straight from the FIFO head and the flag registers.
    assign head_word  = mem_q[rd_ptr_q];
    assign pix_valid  = (count_q != '0);
    assign pix_data   = head_word[DW-1:0];
    assign pix_sof    = head_word[DW+2];
    assign pix_eol    = head_word[DW+1];
    assign pix_eof    = head_word[DW];
    assign overflow   = overflow_q;
    assign short_read = short_read_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: directed scenarios plus a randomized
// run scored against a row-level reference model of the readout stream.

module tb_pixel_readout;

    localparam int COLS       = 2;
    localparam int DW         = 8;
    localparam int SETTLE_CYC = 2;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic          eof;
        logic [DW-1:0] code;
    } word_t;

    logic                clk       = 1'b0;
    logic                reset     = 1'b0;
    logic                read1     = 1'b0;
    logic                read2     = 1'b0;
    logic [COLS*DW-1:0]  data_in   = '0;
    logic                pix_ready = 1'b0;
    logic                pix_valid;
    logic [DW-1:0]       pix_data;
    logic                pix_sof;
    logic                pix_eol;
    logic                pix_eof;
    logic                overflow;
    logic                short_read;
    logic                busy;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    word_t obsQ[$];
    word_t expQ[$];

    pixel_readout #(
        .COLS       (COLS),
        .DW         (DW),
        .SETTLE_CYC (SETTLE_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read1      (read1),
        .read2      (read2),
        .data_in    (data_in),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .overflow   (overflow),
        .short_read (short_read),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges despite its own cycle budgets.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference code mapping: binary value is the XOR of all right-shifts of the gray code.
    function automatic logic [DW-1:0] refCode(input logic [DW-1:0] raw);
        logic [DW-1:0] b;
        b = raw;
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
        for (int s = 1; s < DW; s++) b = b ^ (raw >> s);
`endif
        return b;
    endfunction

    // Reference row: every column of one captured row, tagged by row/column position.
    task automatic modelRow(input logic row, input logic [COLS*DW-1:0] d);
        word_t w;
        for (int c = 0; c < COLS; c++) begin
            w.sof  = (row == 1'b0) && (c == 0);
            w.eol  = (c == COLS - 1);
            w.eof  = (row == 1'b1) && (c == COLS - 1);
            w.code = refCode(d[c*DW +: DW]);
            expQ.push_back(w);
        end
    endtask

    // One clock: record the head if it is being popped at the coming edge, then
    // advance to 1 time unit past the edge where outputs are stable.
    task automatic step();
        if (pix_valid && pix_ready) obsQ.push_back({pix_sof, pix_eol, pix_eof, pix_data});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Strobe pulse: which=1 read1, 2 read2, 3 both; held for len edges with data on the bus.
    task automatic applyStimulus(input int which, input int len, input logic [COLS*DW-1:0] d);
        data_in = d;
        read1   = (which == 1) || (which == 3);
        read2   = (which == 2) || (which == 3);
        repeat (len) step();
        read1 = 1'b0;
        read2 = 1'b0;
    endtask

    // Run until the block is idle and empty, optionally toggling ready randomly.
    task automatic drain(input int budget, input bit randReady, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (randReady) pix_ready = 1'($urandom_range(0, 1));
            step();
        end
        if (!ok && !busy) ok = 1'b1;
        pix_ready = 1'b1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        read1 = 1'b0;
        read2 = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_reset();
        bit ok;
        #1;
        vectors++;
        if ({pix_valid, pix_data, pix_sof, pix_eol, pix_eof, overflow, short_read, busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %b required 0",
                     {pix_valid, pix_data, pix_sof, pix_eol, pix_eof, overflow, short_read, busy});
        end
        reset = 1'b1;
        step();
        step();
        pix_ready = 1'b1;
        data_in   = 16'h2211;
        read1     = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_in_capture: got %b required 1", busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({pix_valid, pix_data, pix_sof, pix_eol, pix_eof, overflow, short_read, busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_capture: got %b required 0",
                     {pix_valid, pix_data, pix_sof, pix_eol, pix_eof, overflow, short_read, busy});
        end
        step();
        step();
        reset = 1'b1;
        read1 = 1'b0;
        obsQ.delete();
        repeat (12) step();
        drain(20, 1'b0, ok);
        vectors++;
        if (obsQ.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: got words=%0d busy=%b required words=0 busy=0",
                     obsQ.size(), busy);
        end
    endtask

    task automatic test_normal_frame();
        bit ok;
        int c0;
        int firstValid;
        doReset();
        pix_ready  = 1'b1;
        firstValid = -1;
        c0         = cyc;
        data_in    = 16'h2211;
        read1      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pix_valid && firstValid < 0) firstValid = cyc - c0;
        end
        read1 = 1'b0;
        repeat (2) step();
        applyStimulus(2, 5, 16'h4433);
        drain(50, 1'b0, ok);
        modelRow(1'b0, 16'h2211);
        modelRow(1'b1, 16'h4433);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL frame_drain: got timeout required idle");
        end
        vectors++;
        if (firstValid !== SETTLE_CYC + 2) begin
            miscompares++;
            $display("[TB] FAIL first_valid_latency: got %0d required %0d", firstValid, SETTLE_CYC + 2);
        end
        vectors++;
        if (obsQ.size() !== expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL frame_count: got %0d required %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL frame_word%0d: got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
        vectors++;
        if ({overflow, short_read} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL frame_flags: got %b required 00", {overflow, short_read});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        word_t head;
        doReset();
        pix_ready = 1'b0;
        applyStimulus(1, 5, 16'h2211);
        repeat (2) step();
        applyStimulus(2, 5, 16'h4433);
        repeat (4) step();
        modelRow(1'b0, 16'h2211);
        modelRow(1'b1, 16'h4433);
        head = {pix_sof, pix_eol, pix_eof, pix_data};
        vectors++;
        if (pix_valid !== 1'b1 || head !== expQ[0] || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_held: got valid=%b head=%h ovf=%b required valid=1 head=%h ovf=0",
                     pix_valid, head, overflow, expQ[0]);
        end
        applyStimulus(1, 5, 16'h6655);
        repeat (3) step();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_overflow: got %b required 1", overflow);
        end
        pix_ready = 1'b1;
        drain(50, 1'b0, ok);
        vectors++;
        if (!ok || obsQ.size() !== expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d (ok=%b) required %0d", obsQ.size(), ok, expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL bp_word%0d: got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_short_read();
        doReset();
        pix_ready = 1'b1;
        data_in   = 16'($urandom);
        read1     = 1'b1;
        step();
        read1 = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL short_settle_busy: got %b required 1", busy);
        end
        step();
        vectors++;
        if (short_read !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL short_flag: got short=%b busy=%b required short=1 busy=0", short_read, busy);
        end
        repeat (8) step();
        vectors++;
        if (obsQ.size() !== 0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL short_no_words: got words=%0d ovf=%b required 0/0", obsQ.size(), overflow);
        end
    endtask

    task automatic test_gray();
        bit ok;
        logic [DW-1:0] want0;
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
        want0 = 8'h80;
`else
        want0 = 8'hC0;
`endif
        doReset();
        pix_ready = 1'b1;
        applyStimulus(1, 5, {8'h5A, 8'hC0});
        drain(50, 1'b0, ok);
        vectors++;
        if (!ok || obsQ.size() !== COLS) begin
            miscompares++;
            $display("[TB] FAIL gray_count: got %0d required %0d", obsQ.size(), COLS);
        end else begin
            vectors++;
            if (obsQ[0].code !== want0 || obsQ[1].code !== refCode(8'h5A)) begin
                miscompares++;
                $display("[TB] FAIL gray_codes: got %h %h required %h %h",
                         obsQ[0].code, obsQ[1].code, want0, refCode(8'h5A));
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [COLS*DW-1:0] d;
        doReset();
        pix_ready = 1'b1;
        d = 16'($urandom);
        applyStimulus(3, 5, d);
        drain(50, 1'b0, ok);
        modelRow(1'b0, d);
        vectors++;
        if (!ok || obsQ.size() !== COLS) begin
            miscompares++;
            $display("[TB] FAIL simul_count: got %0d required %0d", obsQ.size(), COLS);
        end else begin
            vectors++;
            if (obsQ[0] !== expQ[0] || obsQ[1] !== expQ[1]) begin
                miscompares++;
                $display("[TB] FAIL simul_words: got %h %h required %h %h", obsQ[0], obsQ[1], expQ[0], expQ[1]);
            end
        end
        obsQ.delete();
        expQ.delete();
        d       = 16'($urandom);
        data_in = d;
        read1   = 1'b1;
        repeat (3) step();
        read2 = 1'b1;
        repeat (2) step();
        read1 = 1'b0;
        repeat (4) step();
        read2 = 1'b0;
        drain(50, 1'b0, ok);
        modelRow(1'b0, d);
        vectors++;
        if (!ok || obsQ.size() !== COLS) begin
            miscompares++;
            $display("[TB] FAIL capture_ignore_count: got %0d required %0d", obsQ.size(), COLS);
        end else begin
            vectors++;
            if (obsQ[0] !== expQ[0] || obsQ[1] !== expQ[1]) begin
                miscompares++;
                $display("[TB] FAIL capture_ignore_words: got %h %h required %h %h",
                         obsQ[0], obsQ[1], expQ[0], expQ[1]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        bit allOk;
        bit shortExp;
        logic row;
        int len;
        logic [COLS*DW-1:0] d;
        doReset();
        shortExp = 1'b0;
        allOk    = 1'b1;
        for (int it = 0; it < 40; it++) begin
            row = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            d   = 16'($urandom);
            if (len >= SETTLE_CYC + 1) modelRow(row, d);
            else shortExp = 1'b1;
            data_in = d;
            read1   = (row == 1'b0);
            read2   = (row == 1'b1);
            for (int k = 0; k < len; k++) begin
                pix_ready = 1'($urandom_range(0, 1));
                step();
            end
            read1 = 1'b0;
            read2 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                pix_ready = 1'($urandom_range(0, 1));
                step();
            end
            drain(100, 1'b1, ok);
            if (!ok) allOk = 1'b0;
            step();
        end
        vectors++;
        if (!allOk || obsQ.size() !== expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL rand_count: got %0d (drained=%b) required %0d", obsQ.size(), allOk, expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL rand_word%0d: got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
        vectors++;
        if (short_read !== shortExp || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_flags: got short=%b ovf=%b required short=%b ovf=0",
                     short_read, overflow, shortExp);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_normal_frame();
        test_backpressure();
        test_short_read();
        test_gray();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Readout stage directly downstream of the pixel sequencer. It consumes the `read1`/`read2` row strobes and the shared column data bus of the pixel array, and captures one row of ADC codes per strobe. It serialises the codes, tagged with frame and line markers, through a small FIFO onto a valid/ready pixel stream for the off-chip interface.

## Interface
- `COLS`, 2, pixels per row (columns on `data_in`)
- `DW`, 8, bits per pixel code
- `SETTLE_CYC`, 2, cycles to wait after a strobe rising edge before sampling `data_in` (≥1)
- `FIFO_DEPTH`, 4, entries in output FIFO (power of two, ≥2)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `read1`  in  1  row-0 read strobe from pixel sequencer (level)
- `read2`  in  1  row-1 read strobe from pixel sequencer (level)
- `data_in`  in  COLS*DW  column bus; column c at bits [c*DW +: DW]
- `pix_ready`  in  1  downstream ready
- `pix_valid`  out  1  FIFO head valid
- `pix_data`  out  DW  pixel code at FIFO head
- `pix_sof`  out  1  head is row 0, column 0
- `pix_eol`  out  1  head is column COLS-1
- `pix_eof`  out  1  head is row 1, column COLS-1
- `overflow`  out  1  sticky: a word was dropped on full FIFO
- `short_read`  out  1  sticky: strobe fell before sampling
- `busy`  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- Strobe edge detect: `read1_q`/`read2_q` registered. A rise is strobe=1 and _q=0 at the same clock edge.
- Edges are accepted only in IDLE. Edges in other states are ignored and not queued.
- If both rises occur in the same cycle, `read1` wins (row 0) and `read2` is ignored.
- FSM:
  - IDLE: on an accepted rise, latch row (0 for `read1`, 1 for `read2`), clear the counter, and go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles. The selected strobe is checked every cycle.
    - If the strobe is 0, go to IDLE, set `short_read`, and write nothing.
    - On the last cycle, snapshot `data_in` into a COLS*DW shadow register and go to CAPTURE.
  - CAPTURE: write one word per cycle, column 0 first, over COLS cycles, then go to IDLE. The strobe is not checked.
- FIFO entry is {sof, eol, eof, code}, DW+3 bits. Tags are computed from row and column at write time.
- A write is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and the pointers are unchanged.
  - CAPTURE still advances to the next column after a drop.
- Pop when `pix_valid` and `pix_ready`. Pointers wrap modulo FIFO_DEPTH, and count has log2(FIFO_DEPTH)+1 bits.
- Sticky flags clear only on reset.
- Reset mid-operation: state returns to IDLE, the FIFO is emptied, and all partial data is discarded.

## Timing
- Reset values:
  - All outputs are 0: `pix_valid`, `pix_data`, `pix_sof`, `pix_eol`, `pix_eof`, `overflow`, `short_read`, `busy`.
  - FIFO is empty, state is IDLE, and `read1_q`/`read2_q` are 0.
- Rise detected at edge N. SETTLE covers cycles N+1..N+SETTLE_CYC. `data_in` is sampled at the closing edge of cycle N+SETTLE_CYC.
- CAPTURE writes in cycles N+SETTLE_CYC+1 .. N+SETTLE_CYC+COLS.
- `pix_valid` is first high in cycle N+SETTLE_CYC+2, i.e. N+4 with defaults. Output is first-word-fall-through.
- Strobe hold requirement: ≥ SETTLE_CYC+1 cycles. The sequencer's 5-cycle read phase satisfies this with defaults.
- `busy` is combinational from state and count. All other outputs are registered or come directly from FIFO storage.

## Configuration
- `PIXEL_READOUT_GRAY_DECODE_EN` defined: each code is gray-to-binary converted at FIFO write, with no added latency.
  - b[DW-1] = g[DW-1]
  - b[i] = b[i+1] ^ g[i]
- Undefined: codes pass through unchanged.

## Test plan
- Reset: assert `reset`=0 in the middle of CAPTURE. All outputs are 0 within the same cycle. After release, no words appear.
- Normal frame, macro undefined, `pix_ready`=1:
  - Stimulus: `read1` high 5 cycles with `data_in`=16'h2211, then `read2` high 5 cycles with `data_in`=16'h4433.
  - Response: stream 11(sof), 22(eol), 33, 44(eol,eof). First `pix_valid` at N+4. No flags set.
- Backpressure: `pix_ready`=0, run full frame → 4 words held, `overflow`=0. Another `read1` pulse → both words dropped, `overflow`=1. Release ready → original 4 words out in order.
- Short read: `read1` high 1 cycle → no words, `short_read`=1, back to IDLE after 1 SETTLE cycle.
- Gray: column 0 = 8'hC0 → output 8'h80 with `PIXEL_READOUT_GRAY_DECODE_EN`, 8'hC0 without.
- Simultaneous rises of `read1` and `read2` → only row 0 captured (sof on first word, no eof). A `read2` rise during CAPTURE is ignored.
